// File: rtl/dm_bist.sv
// rtl/dm_bist.sv - data memory built-in self-test initiator
//
// Writes a deterministic address/data walk into dm, re-reads the same walk,
// compares every returned word and reports pass/fail, mismatch count and the
// first failing location. Muxed onto dm by the integrator while o_busy is high.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               run request (accepted only in IDLE or DONE, level)
//   o_dm_addr/o_dm_wr/o_dm_rd/o_dm_wdata   dm master strobes
//   i_dm_rdata            dm read data, valid the cycle after o_dm_rd
//   o_busy                run in progress (WRITE, READ, DRAIN)
//   o_done, o_pass        run finished; pass qualified by done
//   o_err_cnt             mismatch count, saturating at 255
//   o_fail_addr/o_fail_exp/o_fail_got       first mismatch details
module dm_bist #(
  parameter int AW        = 7,
  parameter int DW        = 32,
  parameter int NUM_OPS   = 100,
  parameter int ADDR_STEP = 5,
  parameter int DATA_INC  = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [AW-1:0] o_dm_addr,
  output logic          o_dm_wr,
  output logic          o_dm_rd,
  output logic [DW-1:0] o_dm_wdata,
  input  logic [DW-1:0] i_dm_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic [7:0]    o_err_cnt,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_exp,
  output logic [DW-1:0] o_fail_got
);

  localparam int CW = $clog2(NUM_OPS + 1);
  localparam logic [AW-1:0] STEP_A = AW'(ADDR_STEP);
  localparam logic [DW-1:0] INC_D  = DW'(DATA_INC);
  localparam logic [CW-1:0] LAST_OP = CW'(NUM_OPS);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_exp_addr;
  logic [DW-1:0] r_exp;
  logic          r_cmp_vld;
  logic [7:0]    r_err_cnt;
  logic [AW-1:0] r_fail_addr;
  logic [DW-1:0] r_fail_exp;
  logic [DW-1:0] r_fail_got;
  logic          w_last;
  logic          w_start_ok;
  logic          w_mismatch;

  assign w_last     = (r_op == LAST_OP);
  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_mismatch = r_cmp_vld && (i_dm_rdata != r_exp);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_WRITE;
      S_WRITE: if (w_last)  w_next = S_READ;
      S_READ:  if (w_last)  w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (i_start) w_next = S_WRITE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // drops them immediately, without waiting for a clock edge.
  always_comb begin
    o_dm_wr    = 1'b0;
    o_dm_rd    = 1'b0;
    o_dm_addr  = '0;
    o_dm_wdata = '0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_WRITE: begin
        o_dm_wr    = 1'b1;
        o_dm_addr  = r_addr;
        o_dm_wdata = r_data;
        o_busy     = 1'b1;
      end
      S_READ: begin
        o_dm_rd   = 1'b1;
        o_dm_addr = r_addr;
        o_busy    = 1'b1;
      end
      S_DRAIN: o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_pass      = o_done && (r_err_cnt == 8'd0);
  assign o_err_cnt   = r_err_cnt;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_got  = r_fail_got;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_exp_addr  <= '0;
      r_exp       <= '0;
      r_cmp_vld   <= 1'b0;
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else begin
      r_state <= w_next;

      // Expected word trails the read issue by one cycle to line up with rdata.
      r_cmp_vld <= (r_state == S_READ);
      if (r_state == S_READ) begin
        r_exp      <= r_data;
        r_exp_addr <= r_addr;
      end

      if (w_start_ok) begin
        r_op   <= CW'(1);
        r_addr <= STEP_A;
        r_data <= INC_D;
      end else if (r_state == S_WRITE || r_state == S_READ) begin
        if (w_last) begin
          // Rewind to op 1 so READ re-walks exactly the written sequence.
          r_op   <= CW'(1);
          r_addr <= STEP_A;
          r_data <= INC_D;
        end else begin
          r_op   <= r_op + CW'(1);
          r_addr <= r_addr + STEP_A;
          r_data <= r_data + INC_D;
        end
      end

      // A compare never coincides with an accepted start, so the two
      // branches below touch the error state in disjoint cycles.
      if (w_start_ok) begin
        r_err_cnt   <= '0;
        r_fail_addr <= '0;
        r_fail_exp  <= '0;
        r_fail_got  <= '0;
      end else if (w_mismatch) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        if (r_err_cnt == 8'd0) begin
          r_fail_addr <= r_exp_addr;
          r_fail_exp  <= r_exp;
          r_fail_got  <= i_dm_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_bist.sv
// tb/tb_dm_bist.sv - self-checking bench for dm_bist
module tb_dm_bist;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int CAW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v;
  logic       scrub;
  logic       flip_en, flip_all;
  logic [AW-1:0] flip_addr;

  logic [AW-1:0] a_addr;  logic a_wr, a_rd;  logic [DW-1:0] a_wdata, a_rdata;
  logic a_busy, a_done, a_pass;  logic [7:0] a_err;
  logic [AW-1:0] a_faddr;  logic [DW-1:0] a_fexp, a_fgot;

  logic [AW-1:0] b_addr;  logic b_wr, b_rd;  logic [DW-1:0] b_wdata, b_rdata;
  logic b_busy, b_done, b_pass;  logic [7:0] b_err;
  logic [AW-1:0] b_faddr;  logic [DW-1:0] b_fexp, b_fgot;

  logic [CAW-1:0] c_addr;  logic c_wr, c_rd;  logic [DW-1:0] c_wdata, c_rdata;
  logic c_busy, c_done, c_pass;  logic [7:0] c_err;
  logic [CAW-1:0] c_faddr;  logic [DW-1:0] c_fexp, c_fgot;

  logic [2:0] busy_v, done_v;
  assign busy_v = {c_busy, b_busy, a_busy};
  assign done_v = {c_done, b_done, a_done};

  dm_bist u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]),
    .o_dm_addr(a_addr), .o_dm_wr(a_wr), .o_dm_rd(a_rd), .o_dm_wdata(a_wdata),
    .i_dm_rdata(a_rdata), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_err_cnt(a_err), .o_fail_addr(a_faddr), .o_fail_exp(a_fexp), .o_fail_got(a_fgot));

  dm_bist #(.NUM_OPS(128), .ADDR_STEP(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]),
    .o_dm_addr(b_addr), .o_dm_wr(b_wr), .o_dm_rd(b_rd), .o_dm_wdata(b_wdata),
    .i_dm_rdata(b_rdata), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_err_cnt(b_err), .o_fail_addr(b_faddr), .o_fail_exp(b_fexp), .o_fail_got(b_fgot));

  dm_bist #(.AW(CAW), .NUM_OPS(300), .ADDR_STEP(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]),
    .o_dm_addr(c_addr), .o_dm_wr(c_wr), .o_dm_rd(c_rd), .o_dm_wdata(c_wdata),
    .i_dm_rdata(c_rdata), .o_busy(c_busy), .o_done(c_done), .o_pass(c_pass),
    .o_err_cnt(c_err), .o_fail_addr(c_faddr), .o_fail_exp(c_fexp), .o_fail_got(c_fgot));

  // Memory models: registered read, optional bit-0 corruption; c always corrupts.
  logic [DW-1:0] mem_a [128];
  logic [DW-1:0] mem_b [128];
  logic [DW-1:0] mem_c [512];
  always @(posedge clk) begin
    if (scrub) begin
      for (int k = 0; k < 512; k++) begin
        if (k < 128) begin
          mem_a[k] <= 32'hDEAD_0000 | 32'(k);
          mem_b[k] <= 32'hBEEF_0000 | 32'(k);
        end
        mem_c[k] <= 32'hCAFE_0000 | 32'(k);
      end
    end else begin
      if (a_wr) mem_a[a_addr] <= a_wdata;
      if (a_rd) a_rdata <= mem_a[a_addr] ^ {31'd0, flip_all | (flip_en & (a_addr == flip_addr))};
      if (b_wr) mem_b[b_addr] <= b_wdata;
      if (b_rd) b_rdata <= mem_b[b_addr];
      if (c_wr) mem_c[c_addr] <= c_wdata;
      if (c_rd) c_rdata <= mem_c[c_addr] ^ 32'd1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic sb_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s got=unexpected_op exp=no_op", name);
  endtask

  // Scoreboard for instance a.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
  op_t           wq[$];
  logic [AW-1:0] rq[$];

  task automatic sb_push();
    for (int i = 1; i <= 100; i++) begin
      op_t e;
      e.addr = AW'((i * 5) % 128);
      e.data = DW'(i * 10);
      wq.push_back(e);
      rq.push_back(e.addr);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_wr || a_rd) chk("wr_rd_excl", {63'd0, a_wr & a_rd}, 64'd0);
      if (a_wr) begin
        if (wq.size() == 0) sb_fail("sb_extra_wr");
        else begin
          op_t e;
          e = wq.pop_front();
          chk("sb_waddr", 64'(a_addr), 64'(e.addr));
          chk("sb_wdata", 64'(a_wdata), 64'(e.data));
        end
      end
      if (a_rd) begin
        if (rq.size() == 0) sb_fail("sb_extra_rd");
        else chk("sb_raddr", 64'(a_addr), 64'(rq.pop_front()));
      end
      if (!a_wr && !a_rd && (a_addr != '0 || a_wdata != '0)) begin
        chk("idle_addr", 64'(a_addr), 64'd0);
        chk("idle_wdata", 64'(a_wdata), 64'd0);
      end
    end
  end

  int b_wr_cnt = 0;
  logic [AW-1:0] b_last_waddr = '0;
  always @(negedge clk) begin
    if (!rst && b_wr) begin
      b_wr_cnt = b_wr_cnt + 1;
      b_last_waddr = b_addr;
    end
  end

  task automatic do_scrub();
    @(negedge clk) scrub = 1'b1;
    @(negedge clk) scrub = 1'b0;
  endtask

  // Start pulse sampled at edge 0; returns the cycle in which done first shows.
  task automatic run(input int sel, input bit mid_start, output int done_cyc);
    int cyc;
    @(negedge clk);
    if (sel == 0) sb_push();
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1 start_v[sel] = 1'b0;
    cyc = 0;
    done_cyc = -1;
    chk($sformatf("busy_c1_%0d", sel), 64'(busy_v[sel]), 64'd1);
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (mid_start) start_v[sel] = (cyc == 10);
      if (done_v[sel]) begin
        done_cyc = cyc + 1;
        break;
      end
    end
    start_v[sel] = 1'b0;
  endtask

  typedef struct {
    bit            flip;
    bit            all;
    logic [AW-1:0] faddr_in;
    bit            mid_start;
    logic [7:0]    exp_err;
    logic [AW-1:0] exp_faddr;
    logic [DW-1:0] exp_fexp;
    logic [DW-1:0] exp_fgot;
    bit            exp_pass;
  } vec_t;

  vec_t vecs[6];
  int   dc;

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr"}, 64'(a_wr), 64'd0);
    chk({tag, "_rd"}, 64'(a_rd), 64'd0);
    chk({tag, "_addr"}, 64'(a_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(a_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_done"}, 64'(a_done), 64'd0);
    chk({tag, "_pass"}, 64'(a_pass), 64'd0);
    chk({tag, "_err"}, 64'(a_err), 64'd0);
    chk({tag, "_faddr"}, 64'(a_faddr), 64'd0);
    chk({tag, "_fexp"}, 64'(a_fexp), 64'd0);
    chk({tag, "_fgot"}, 64'(a_fgot), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_v = '0; scrub = 1'b0;
    flip_en = 1'b0; flip_all = 1'b0; flip_addr = '0;

    //           flip all addr mid  err     faddr  fexp          fgot          pass
    vecs[0] = '{1'b0, 1'b0, 7'h00, 1'b0, 8'd0,   7'h00, 32'd0,    32'd0,    1'b1};
    vecs[1] = '{1'b1, 1'b0, 7'h23, 1'b0, 8'd1,   7'h23, 32'd70,   32'd71,   1'b0};
    vecs[2] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'd0,   7'h00, 32'd0,    32'd0,    1'b1};
    vecs[3] = '{1'b1, 1'b0, 7'h74, 1'b0, 8'd1,   7'h74, 32'd1000, 32'd1001, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 7'h05, 1'b0, 8'd1,   7'h05, 32'd10,   32'd11,   1'b0};
    vecs[5] = '{1'b0, 1'b1, 7'h00, 1'b0, 8'd100, 7'h05, 32'd10,   32'd11,   1'b0};

    #12;
    chk_zero_outputs("reset");
    chk("reset_b_busy", 64'(b_busy), 64'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      flip_en = vecs[i].flip; flip_all = vecs[i].all; flip_addr = vecs[i].faddr_in;
      do_scrub();
      run(0, vecs[i].mid_start, dc);
      chk($sformatf("v%0d_done_cyc", i), 64'(dc), 64'd202);
      chk($sformatf("v%0d_err", i), 64'(a_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_faddr", i), 64'(a_faddr), 64'(vecs[i].exp_faddr));
      chk($sformatf("v%0d_fexp", i), 64'(a_fexp), 64'(vecs[i].exp_fexp));
      chk($sformatf("v%0d_fgot", i), 64'(a_fgot), 64'(vecs[i].exp_fgot));
      chk($sformatf("v%0d_pass", i), 64'(a_pass), 64'(vecs[i].exp_pass));
      chk($sformatf("v%0d_busy", i), 64'(a_busy), 64'd0);
      chk($sformatf("v%0d_wq_left", i), 64'(wq.size()), 64'd0);
      chk($sformatf("v%0d_rq_left", i), 64'(rq.size()), 64'd0);
    end
    flip_en = 1'b0; flip_all = 1'b0;

    // Results hold in DONE, then an asynchronous mid-cycle reset clears everything.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", 64'(a_done), 64'd1);
    chk("hold_err", 64'(a_err), 64'd100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("async_rst");
    @(negedge clk) rst = 1'b0;

    // Reset at cycle 50 of a run: strobes drop without an edge, no done follows.
    do_scrub();
    @(negedge clk);
    sb_push();
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1 chk("mid_wr_before", 64'(a_wr), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr", 64'(a_wr), 64'd0);
    chk("mid_rst_busy", 64'(a_busy), 64'd0);
    chk("mid_rst_done", 64'(a_done), 64'd0);
    @(negedge clk) rst = 1'b0;
    wq.delete();
    rq.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_rst_busy", 64'(a_busy), 64'd0);
    chk("idle_after_rst_done", 64'(a_done), 64'd0);
    run(0, 1'b0, dc);
    chk("post_rst_done_cyc", 64'(dc), 64'd202);
    chk("post_rst_pass", 64'(a_pass), 64'd1);
    chk("post_rst_err", 64'(a_err), 64'd0);
    chk("post_rst_wq_left", 64'(wq.size()), 64'd0);

    // Full-memory walk with address wrap.
    run(1, 1'b0, dc);
    chk("b_done_cyc", 64'(dc), 64'd258);
    chk("b_pass", 64'(b_pass), 64'd1);
    chk("b_err", 64'(b_err), 64'd0);
    chk("b_wr_cnt", 64'(b_wr_cnt), 64'd128);
    chk("b_last_waddr", 64'(b_last_waddr), 64'd0);

    // Every read corrupted, 300 ops: count saturates at 255.
    run(2, 1'b0, dc);
    chk("c_done_cyc", 64'(dc), 64'd602);
    chk("c_err_sat", 64'(c_err), 64'd255);
    chk("c_faddr", 64'(c_faddr), 64'd1);
    chk("c_fexp", 64'(c_fexp), 64'd10);
    chk("c_fgot", 64'(c_fgot), 64'd11);
    chk("c_pass", 64'(c_pass), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
